wram_port_arb: RTL

//   Arbitrates the single-port WRAM block RAM between the AXI write path (decoded internal write beats)
//   and the compute-side weight-read requester. Sequences each BRAM cycle (ena/wea/addr/din) and returns

---
 rtl/wram_arb_pkg.sv | 15 +
 rtl/wram_rd_lat_pipe.sv | 24 ++
 rtl/wram_port_arb.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/wram_arb_pkg.sv
// Shared types for the WRAM port arbiter: FSM state encoding and AXI region codes.
package wram_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic [1:0] REGION_FIFO = 2'd0;
  localparam logic [1:0] REGION_IRAM = 2'd1;
  localparam logic [1:0] REGION_WRAM = 2'd2;
  localparam logic [1:0] REGION_RSVD = 2'd3;

endpackage

// File: rtl/wram_rd_lat_pipe.sv
// Read-valid delay line: a push in cycle N appears on vld in cycle N+DEPTH.
module wram_rd_lat_pipe #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  output logic vld
);

  logic [DEPTH-1:0] vld_q;

  // Async clear drops any read still in flight so it never reports valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[DEPTH-2:0], push};
    end
  end

  assign vld = vld_q[DEPTH-1];

endmodule

// File: rtl/wram_port_arb.sv
// Single-port WRAM arbiter between AXI write beats and compute weight reads.
// Define WRAM_ARB_FAIR_EN to bound consecutive read grants while a write waits.
module wram_port_arb
  import wram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned STRB_W      = 4,
  parameter int unsigned RD_LAT      = 1,
  parameter logic [1:0]  WRAM_REGION = REGION_WRAM,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              axi_wr_vld,
  input  logic [1:0]        axi_wr_region,
  input  logic [ADDR_W-1:0] axi_wr_addr,
  input  logic [DATA_W-1:0] axi_wr_data,
  input  logic [STRB_W-1:0] axi_wr_strb,
  output logic              wram_wr_done,
  input  logic              rd_req_vld,
  output logic              rd_req_rdy,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_data_vld,
  output logic [DATA_W-1:0] rd_data,
  output logic              ram_ena,
  output logic [STRB_W-1:0] ram_wea,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  if (RD_LAT < 1 || RD_LAT > 2 || STRB_W * 8 != DATA_W || STARVE_MAX < 1) begin : g_bad_cfg
    $error("wram_port_arb: illegal parameter combination");
  end

  state_t            state;
  state_t            state_nxt;
  logic              wr_req;
  logic              force_wr;
  logic              rd_go;
  logic              wr_go;
  logic              ena_nxt;
  logic [STRB_W-1:0] wea_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] din_nxt;
  logic              done_nxt;

  // Beat is masked outside S_IDLE so the beat being acknowledged is not rewritten.
  assign wr_req = axi_wr_vld && (axi_wr_region == WRAM_REGION) && (state == S_IDLE);

`ifdef WRAM_ARB_FAIR_EN
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;

  assign force_wr = wr_req && (starve_cnt == CNT_W'(STARVE_MAX));

  // Read grants taken while a write waits; cleared once the write wins or leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!wr_req || wr_go) begin
      starve_cnt <= '0;
    end else if (rd_go) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`else
  assign force_wr = 1'b0;
`endif

  assign rd_req_rdy = !rst && (state != S_WR) && !force_wr;
  assign rd_go      = rd_req_vld && rd_req_rdy;
  assign wr_go      = wr_req && !rd_go;

  always_comb begin
    state_nxt = state;
    ena_nxt   = 1'b0;
    wea_nxt   = '0;
    addr_nxt  = ram_addr;
    din_nxt   = ram_din;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (rd_go) begin
          ena_nxt  = 1'b1;
          addr_nxt = rd_addr;
        end else if (wr_go) begin
          state_nxt = S_WR;
          ena_nxt   = 1'b1;
          wea_nxt   = axi_wr_strb;
          addr_nxt  = axi_wr_addr;
          din_nxt   = axi_wr_data;
        end
      end
      S_WR: begin
        state_nxt = S_ACK;
        done_nxt  = 1'b1;
      end
      S_ACK: begin
        state_nxt = S_IDLE;
        if (rd_go) begin
          ena_nxt  = 1'b1;
          addr_nxt = rd_addr;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      ram_ena      <= 1'b0;
      ram_wea      <= '0;
      ram_addr     <= '0;
      ram_din      <= '0;
      wram_wr_done <= 1'b0;
    end else begin
      state        <= state_nxt;
      ram_ena      <= ena_nxt;
      ram_wea      <= wea_nxt;
      ram_addr     <= addr_nxt;
      ram_din      <= din_nxt;
      wram_wr_done <= done_nxt;
    end
  end

  wram_rd_lat_pipe #(
    .DEPTH (RD_LAT + 1)
  ) u_rd_lat_pipe (
    .clk  (clk),
    .rst  (rst),
    .push (rd_go),
    .vld  (rd_data_vld)
  );

  assign rd_data = rd_data_vld ? ram_dout : '0;

endmodule
